// File: rtl/prog_load_ctrl_pkg.sv
// Shared types and helpers for the program-load controller.
// Optional checksum feature is selected with PROG_LOAD_CSUM_EN.
package prog_load_ctrl_pkg;

  localparam int ADDR_W_DEF = 11;
  localparam int DATA_W_DEF = 32;
  localparam int CNT_W_DEF  = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ARM,
    RUN,
    HALT
  } state_t;

  // Increment that sticks at the all-ones value of a w-bit counter (w <= 32).
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] top;
    top = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    return (v == top) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/prog_load_ctrl_wr_port.sv
// Registered instruction-memory write stage with session word counter.
// With PROG_LOAD_CSUM_EN defined it also keeps a rotate/XOR checksum of written words.
module prog_load_ctrl_wr_port
  import prog_load_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              accept,
  input  logic              first,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  output logic              w_enable,
  output logic [ADDR_W-1:0] w_adrs,
  output logic [DATA_W-1:0] w_instruction,
  output logic [CNT_W-1:0]  load_count
`ifdef PROG_LOAD_CSUM_EN
  , output logic [DATA_W-1:0] load_csum
`endif
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_enable      <= 1'b0;
      w_adrs        <= '0;
      w_instruction <= '0;
      load_count    <= '0;
    end else begin
      w_enable <= accept;
      if (accept) begin
        w_adrs        <= addr;
        w_instruction <= data;
        // A new session restarts the count at the word being written now.
        load_count    <= first ? CNT_W'(1) : CNT_W'(sat_inc(32'(load_count), CNT_W));
      end
    end
  end

`ifdef PROG_LOAD_CSUM_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_csum <= '0;
    end else if (accept) begin
      load_csum <= (first ? '0 : {load_csum[DATA_W-2:0], load_csum[DATA_W-1]}) ^ data;
    end
  end
`endif

endmodule

// File: rtl/prog_load_ctrl.sv
// Program-load sequencer: streams host writes into instruction memory, then arms and runs the CPU.
// Host stream: a write transfers in any cycle where h_valid && h_ready. Optional: PROG_LOAD_CSUM_EN.
module prog_load_ctrl
  import prog_load_ctrl_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int ARM_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              h_valid,
  output logic              h_ready,
  input  logic [ADDR_W-1:0] h_addr,
  input  logic [DATA_W-1:0] h_data,
  input  logic              start,
  input  logic              stop,
  input  logic [CNT_W-1:0]  run_limit,
  output logic              w_enable,
  output logic [ADDR_W-1:0] w_adrs,
  output logic [DATA_W-1:0] w_instruction,
  output logic              cpu_en,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  load_count
`ifdef PROG_LOAD_CSUM_EN
  , output logic [DATA_W-1:0] load_csum
`endif
);

  state_t           state, state_nx;
  logic [3:0]       arm_cnt;
  logic [CNT_W-1:0] limit_q;
  logic [CNT_W-1:0] cycle_inc;
  logic             accept, first_wr, start_ok, arm_done, limit_hit;

  assign h_ready   = (state == IDLE) || (state == LOAD) || (state == HALT);
  assign accept    = h_valid && h_ready;
  assign first_wr  = accept && ((state == IDLE) || (state == HALT));
  assign start_ok  = start && h_ready;
  assign cycle_inc = CNT_W'(sat_inc(32'(cycle_count), CNT_W));
  // Settle cycles only count once the final write strobe has gone low.
  assign arm_done  = (state == ARM) && !w_enable && (arm_cnt == 4'd1);
  assign limit_hit = (limit_q != '0) && (cycle_inc == limit_q);

  // cpu_en is decoded from state so an async reset drops it immediately.
  assign cpu_en = (state == RUN);
  assign busy   = (state == ARM) || (state == RUN);
  assign done   = (state == HALT);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, HALT: begin
        if (start)       state_nx = ARM;
        else if (accept) state_nx = LOAD;
      end
      LOAD:    if (start) state_nx = ARM;
      ARM: begin
        if (stop)          state_nx = HALT;
        else if (arm_done) state_nx = RUN;
      end
      RUN:     if (stop || limit_hit) state_nx = HALT;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      arm_cnt     <= '0;
      limit_q     <= '0;
      cycle_count <= '0;
    end else begin
      state <= state_nx;
      if (start_ok) begin
        arm_cnt     <= 4'(ARM_CYCLES);
        limit_q     <= run_limit;
        cycle_count <= '0;
      end else if ((state == ARM) && !w_enable) begin
        arm_cnt <= arm_cnt - 4'd1;
      end
      if (state == RUN) cycle_count <= cycle_inc;
    end
  end

  prog_load_ctrl_wr_port #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_wr_port (
    .clk           (clk),
    .reset         (reset),
    .accept        (accept),
    .first         (first_wr),
    .addr          (h_addr),
    .data          (h_data),
    .w_enable      (w_enable),
    .w_adrs        (w_adrs),
    .w_instruction (w_instruction),
    .load_count    (load_count)
`ifdef PROG_LOAD_CSUM_EN
    , .load_csum   (load_csum)
`endif
  );

endmodule

// File: tb/tb_prog_load_ctrl.sv
// Directed bench for prog_load_ctrl: load, timed run, stopped run, ARM abort, async reset.
// Checksum checks are compiled in when PROG_LOAD_CSUM_EN is defined.
module tb_prog_load_ctrl;
  import prog_load_ctrl_pkg::*;

  localparam int ADDR_W = 11;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;

  logic              clk;
  logic              reset;
  logic              h_valid;
  logic              h_ready;
  logic [ADDR_W-1:0] h_addr;
  logic [DATA_W-1:0] h_data;
  logic              start;
  logic              stop;
  logic [CNT_W-1:0]  run_limit;
  logic              w_enable;
  logic [ADDR_W-1:0] w_adrs;
  logic [DATA_W-1:0] w_instruction;
  logic              cpu_en;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  cycle_count;
  logic [CNT_W-1:0]  load_count;
`ifdef PROG_LOAD_CSUM_EN
  logic [DATA_W-1:0] load_csum;
`endif

  int n_checks = 0;
  int n_err    = 0;

  prog_load_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W), .ARM_CYCLES(2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .h_valid       (h_valid),
    .h_ready       (h_ready),
    .h_addr        (h_addr),
    .h_data        (h_data),
    .start         (start),
    .stop          (stop),
    .run_limit     (run_limit),
    .w_enable      (w_enable),
    .w_adrs        (w_adrs),
    .w_instruction (w_instruction),
    .cpu_en        (cpu_en),
    .busy          (busy),
    .done          (done),
    .cycle_count   (cycle_count),
    .load_count    (load_count)
`ifdef PROG_LOAD_CSUM_EN
    , .load_csum   (load_csum)
`endif
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // inputs change and outputs are sampled 1 time unit after each rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [ADDR_W-1:0] addrs [5];
  int                n;
  logic              seen;

  initial begin
    addrs = '{11'd2, 11'd3, 11'd4, 11'd5, 11'd9};
    reset = 1'b1; h_valid = 1'b1; h_addr = 11'd2; h_data = 32'hE000_300A;
    start = 1'b0; stop = 1'b0; run_limit = '0;

    // 1: reset state, then a single write
    #3;
    chk("rst_h_ready", 64'(h_ready), 64'd1);
    chk("rst_cpu_en", 64'(cpu_en), 64'd0);
    chk("rst_w_enable", 64'(w_enable), 64'd0);
    chk("rst_done_busy", 64'({done, busy}), 64'd0);
    tick();
    chk("rst_no_write", 64'(w_enable), 64'd0);
    reset = 1'b0;
    tick();
    h_valid = 1'b0;
    chk("wr1_w_enable", 64'(w_enable), 64'd1);
    chk("wr1_w_adrs", 64'(w_adrs), 64'd2);
    chk("wr1_w_instr", 64'(w_instruction), 64'hE000_300A);
    chk("wr1_load_count", 64'(load_count), 64'd1);
    tick();
    chk("wr1_strobe_1cyc", 64'(w_enable), 64'd0);
    chk("wr1_adrs_hold", 64'(w_adrs), 64'd2);

    // 2: fresh session, five back-to-back writes
    reset = 1'b1; #1; reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      h_valid = 1'b1; h_addr = addrs[i]; h_data = 32'h1000_0000 + 32'(i);
      tick();
      chk("b2b_w_enable", 64'(w_enable), 64'd1);
      chk("b2b_w_adrs", 64'(w_adrs), 64'(addrs[i]));
      chk("b2b_w_instr", 64'(w_instruction), 64'h1000_0000 + 64'(i));
    end
    h_valid = 1'b0;
    chk("b2b_load_count", 64'(load_count), 64'd5);
    chk("b2b_state", 64'(dut.state), 64'(LOAD));

    // 3: bounded run of 20 cycles; last w_enable was the previous cycle
    start = 1'b1; run_limit = 16'd20;
    tick();
    start = 1'b0;
    chk("arm_busy", 64'(busy), 64'd1);
    chk("arm_cpu_en0", 64'(cpu_en), 64'd0);
    tick();
    chk("arm_cpu_en1", 64'(cpu_en), 64'd0);
    tick();
    chk("run_cpu_en_rise", 64'(cpu_en), 64'd1);
    n = 0;
    while (cpu_en && n < 100) begin
      n++;
      tick();
    end
    chk("run_len_20", 64'(n), 64'd20);
    chk("run_done", 64'(done), 64'd1);
    chk("run_cycle_count", 64'(cycle_count), 64'd20);
    chk("run_load_hold", 64'(load_count), 64'd5);

    // 4: unlimited run stopped after 37 RUN cycles; writes refused during RUN
    start = 1'b1; run_limit = 16'd0;
    tick();
    start = 1'b0;
    n = 0;
    while (!cpu_en && n < 10) begin
      n++;
      tick();
    end
    chk("rerun_arm_len", 64'(n), 64'd2);
    chk("rerun_cc0", 64'(cycle_count), 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 36; i++) begin
      h_valid = (i % 5 == 0); h_addr = 11'h7FF; h_data = 32'hDEAD_BEEF;
      if (h_valid) chk("run_h_ready0", 64'(h_ready), 64'd0);
      tick();
      seen = seen | w_enable | !cpu_en;
    end
    h_valid = 1'b0;
    chk("run_no_write_or_drop", 64'(seen), 64'd0);
    chk("run_cc36", 64'(cycle_count), 64'd36);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_cpu_en", 64'(cpu_en), 64'd0);
    chk("stop_done", 64'(done), 64'd1);
    chk("stop_cc37", 64'(cycle_count), 64'd37);

    // 5: abort from ARM, then start together with final write
    start = 1'b1;
    tick();
    start = 1'b0; stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("abort_done", 64'(done), 64'd1);
    chk("abort_cc0", 64'(cycle_count), 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      seen = seen | cpu_en;
    end
    chk("abort_never_run", 64'(seen), 64'd0);
    h_valid = 1'b1; h_addr = 11'd7; h_data = 32'hA5A5_0007;
    tick();
    chk("halt_wr_done0", 64'(done), 64'd0);
    chk("halt_wr_lc1", 64'(load_count), 64'd1);
    h_addr = 11'd8; h_data = 32'hA5A5_0008; start = 1'b1; run_limit = 16'd3;
    tick();
    h_valid = 1'b0; start = 1'b0;
    chk("startwr_w_enable", 64'(w_enable), 64'd1);
    chk("startwr_w_adrs", 64'(w_adrs), 64'd8);
    chk("startwr_state", 64'(dut.state), 64'(ARM));
    chk("startwr_lc2", 64'(load_count), 64'd2);
    tick();
    chk("startwr_idle1", 64'(cpu_en), 64'd0);
    tick();
    chk("startwr_idle2", 64'(cpu_en), 64'd0);
    tick();
    chk("startwr_run", 64'(cpu_en), 64'd1);

    // 6: asynchronous reset mid-RUN
    tick();
    chk("mid_run_cc1", 64'(cycle_count), 64'd1);
    reset = 1'b1;
    #1;
    chk("async_cpu_en", 64'(cpu_en), 64'd0);
    chk("async_counts", 64'({cycle_count, load_count}), 64'd0);
    chk("async_h_ready", 64'(h_ready), 64'd1);
    tick();
    reset = 1'b0;

`ifdef PROG_LOAD_CSUM_EN
    h_valid = 1'b1; h_addr = 11'd0; h_data = 32'h1;
    tick();
    chk("csum_first", 64'(load_csum), 64'h1);
    h_data = 32'h2;
    tick();
    h_valid = 1'b0;
    chk("csum_second", 64'(load_csum), 64'h0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/prog_load_ctrl.md
Name: prog_load_ctrl

Overview:
Sequencer that owns the CPU's instruction-memory write port and run enable. It accepts address/word pairs from a host over a valid/ready stream and drives them onto w_enable/w_adrs/w_instruction while the CPU is held stopped. On a start command it waits a settle gap, raises cpu_en for a bounded or unbounded run, then halts. It sits between the host interface and top_level and replaces hand-driven loading of the program.

Parameters:
ADDR_W, 11, instruction-memory address width (w_adrs).
DATA_W, 32, instruction word width.
CNT_W, 16, width of run_limit, cycle_count and load_count.
ARM_CYCLES, 2, idle cycles between the last memory write and cpu_en rising; legal range 1..15.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
h_valid  in  1  host offers a write
h_ready  out  1  controller accepts a write this cycle
h_addr  in  ADDR_W  target instruction address
h_data  in  DATA_W  instruction word
start  in  1  single-cycle pulse: begin a run
stop  in  1  single-cycle pulse: abort a run
run_limit  in  CNT_W  run length in cycles; 0 = unlimited; sampled on accepted start
w_enable  out  1  memory write strobe to CPU
w_adrs  out  ADDR_W  memory write address
w_instruction  out  DATA_W  memory write data
cpu_en  out  1  CPU run enable
busy  out  1  state is ARM or RUN
done  out  1  state is HALT
cycle_count  out  CNT_W  cycles of the current/last run with cpu_en high
load_count  out  CNT_W  words written in the current load session

Behaviour:
- Reset (asynchronous, active-high): state IDLE. All outputs 0 except h_ready=1. Asserting reset mid-RUN drops cpu_en immediately, without waiting for a clock edge.
- States: IDLE, LOAD, ARM, RUN, HALT.
- A write is accepted when h_valid&&h_ready. h_ready=1 in IDLE, LOAD and HALT, and 0 in ARM and RUN.
- Accepted write: on the next edge, register w_enable=1, w_adrs=h_addr and w_instruction=h_data for exactly one cycle. Latency is 1 cycle. Back-to-back writes are allowed at 1 per cycle. w_adrs and w_instruction hold their last values when w_enable=0.
- The first accepted write from IDLE or HALT goes to LOAD, clears done and sets load_count=1. Each further write increments load_count, saturating at all-ones.
- start in IDLE, LOAD or HALT goes to ARM.
  - Start samples run_limit and clears cycle_count.
  - If a write is accepted in the same cycle as start, the write is still performed.
  - ARM lasts ARM_CYCLES cycles after the cycle in which the final w_enable is high.
  - start in ARM or RUN is ignored.
- ARM -> RUN when the settle counter expires. cpu_en=1 from the first RUN cycle.
- RUN:
  - cycle_count increments on every cycle with cpu_en=1, saturating.
  - With run_limit=N>0, cpu_en is high for exactly N cycles, then the state goes to HALT.
  - stop goes to HALT on the next edge; cpu_en is low from that edge.
  - stop in ARM aborts to HALT without cpu_en ever rising.
  - stop in IDLE, LOAD or HALT is ignored.
  - stop and limit expiry in the same cycle are equivalent: HALT.
- HALT: done=1 and cpu_en=0. cycle_count and load_count hold their values. A write re-enters LOAD; start re-runs the existing program.
- Simultaneous start and stop: stop wins in ARM and RUN; start wins elsewhere.

Optional Feature:
PROG_LOAD_CSUM_EN
- Defined:
  - Adds output load_csum [DATA_W-1:0].
  - Running value is rotate-left-by-1 of the previous value, XOR h_data, for each accepted write.
  - It is reset to 0 on the first write of a session and holds through ARM, RUN and HALT.
- Undefined: the port and logic are absent, and all other behaviour is identical.

Decomposition:
- Shared package: state enum (IDLE/LOAD/ARM/RUN/HALT), ADDR_W/DATA_W defaults, and a saturating-increment function.
- One natural sub-module is prog_load_wr_port: the registered write-strobe stage plus load_count and optional checksum. The FSM, settle counter and run counter stay in the top.

Test Plan:
1. Reset with h_valid=1 -> h_ready=1, cpu_en=0, w_enable=0. Release reset; write (2, 0xE000_300A) -> next cycle w_enable=1, w_adrs=2, w_instruction=0xE000_300A, load_count=1.
2. Five back-to-back writes to addresses 2,3,4,5,9 -> five consecutive w_enable cycles in order, load_count=5, state LOAD.
3. start with run_limit=20 and ARM_CYCLES=2 -> cpu_en rises 2 cycles after the last w_enable and stays high exactly 20 cycles, then done=1 and cycle_count=20.
4. start with run_limit=0, then stop after 37 RUN cycles -> cpu_en falls on the next edge, cycle_count=37, done=1. h_valid pulses during RUN see h_ready=0 and produce no w_enable.
5. stop during ARM -> HALT, cpu_en never high, cycle_count=0. A start asserted together with the final write -> write performed, then ARM.
6. Assert reset mid-RUN -> cpu_en low before the next clock edge and all counters 0. With PROG_LOAD_CSUM_EN, writing 0x1 then 0x2 -> load_csum=0x0000_0000.
